// File: rtl/native_bus_arbiter_pkg.sv
// Shared owner IDs, FSM encoding and arbitration helper for the native-bus
// read arbiter and its owner FIFO.
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package native_bus_arbiter_pkg;

  localparam logic OWNER_INSTR = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  // On a tie the master that was not granted last wins, unless data is favoured.
  function automatic logic pick_owner(input logic ir_req, input logic dr_req,
                                      input logic last_grant, input logic data_first);
    logic owner;
    owner = OWNER_INSTR;
    if (ir_req && dr_req) begin
      if (data_first) owner = OWNER_DATA;
      else owner = (last_grant == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
    end else if (dr_req) begin
      owner = OWNER_DATA;
    end
    return owner;
  endfunction

endpackage

// File: rtl/native_owner_fifo.sv
// Small FIFO of 1-bit owner IDs recording who issued each outstanding read,
// so responses can be steered back in issue order.
module native_owner_fifo
  import native_bus_arbiter_pkg::*;
#(
  parameter int depth = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_owner,
  input  logic pop,
  output logic head_owner,
  output logic full,
  output logic empty
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(depth - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(depth);

  logic [depth-1:0] slots;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_owner = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_owner;
        wr_ptr        <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/native_bus_arbiter.sv
// Shares one native-bus memory slave between the instruction-read and data
// masters: arbitrated read issue, in-order response routing, write passthrough.
module native_bus_arbiter
  import native_bus_arbiter_pkg::*;
#(
  parameter int bus_width       = 32,
  parameter int max_outstanding = 2,
  parameter int data_priority   = 0
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 ir_raddr_valid,
  output logic                 ir_raddr_ready,
  input  logic [bus_width-1:0] ir_raddr,
  output logic                 ir_rdata_valid,
  input  logic                 ir_rdata_ready,
  output logic [bus_width-1:0] ir_rdata,

  input  logic                 dr_raddr_valid,
  output logic                 dr_raddr_ready,
  input  logic [bus_width-1:0] dr_raddr,
  output logic                 dr_rdata_valid,
  input  logic                 dr_rdata_ready,
  output logic [bus_width-1:0] dr_rdata,

  input  logic                 dw_waddr_valid,
  output logic                 dw_waddr_ready,
  input  logic [bus_width-1:0] dw_waddr,
  input  logic                 dw_wdata_valid,
  output logic                 dw_wdata_ready,
  input  logic [bus_width-1:0] dw_wdata,

  output logic                 m_raddr_valid,
  input  logic                 m_raddr_ready,
  output logic [bus_width-1:0] m_raddr,
  input  logic                 m_rdata_valid,
  output logic                 m_rdata_ready,
  input  logic [bus_width-1:0] m_rdata,

  output logic                 m_waddr_valid,
  input  logic                 m_waddr_ready,
  output logic [bus_width-1:0] m_waddr,
  output logic                 m_wdata_valid,
  input  logic                 m_wdata_ready,
  output logic [bus_width-1:0] m_wdata,

  output logic                 err_rdata
);

  localparam logic DATA_FIRST = (data_priority != 0);

  logic [0:0] state;
  logic       last_grant;
  logic       winner;
  logic       grant;
  logic       fifo_full;
  logic       fifo_empty;
  logic       head_owner;
  logic       pop;

  assign winner         = pick_owner(ir_raddr_valid, dr_raddr_valid, last_grant, DATA_FIRST);
  assign grant          = (state == IDLE) && !fifo_full && (ir_raddr_valid || dr_raddr_valid);
  assign ir_raddr_ready = grant && (winner == OWNER_INSTR);
  assign dr_raddr_ready = grant && (winner == OWNER_DATA);
  assign m_raddr_valid  = (state == ISSUE);
  assign pop            = m_rdata_valid && m_rdata_ready;

  native_owner_fifo #(
    .depth (max_outstanding)
  ) u_owner_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (grant),
    .push_owner (winner),
    .pop        (pop),
    .head_owner (head_owner),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      m_raddr    <= '0;
      last_grant <= OWNER_DATA;
      err_rdata  <= `FALSE;
    end else begin
      if (state == IDLE) begin
        if (grant) begin
          m_raddr    <= (winner == OWNER_DATA) ? dr_raddr : ir_raddr;
          last_grant <= winner;
          state      <= ISSUE;
        end
      end else if (m_raddr_ready) begin
        state <= IDLE;
      end
      // A response with nothing outstanding is never accepted, only flagged.
      if (m_rdata_valid && fifo_empty) err_rdata <= `TRUE;
    end
  end

  always_comb begin
    ir_rdata_valid = 1'b0;
    dr_rdata_valid = 1'b0;
    m_rdata_ready  = 1'b0;
    if (!fifo_empty) begin
      if (head_owner == OWNER_INSTR) begin
        ir_rdata_valid = m_rdata_valid;
        m_rdata_ready  = ir_rdata_ready;
      end else begin
        dr_rdata_valid = m_rdata_valid;
        m_rdata_ready  = dr_rdata_ready;
      end
    end
  end

  assign ir_rdata = m_rdata;
  assign dr_rdata = m_rdata;

  assign m_waddr_valid  = dw_waddr_valid;
  assign m_waddr        = dw_waddr;
  assign m_wdata_valid  = dw_wdata_valid;
  assign m_wdata        = dw_wdata;
  assign dw_waddr_ready = m_waddr_ready;
  assign dw_wdata_ready = m_wdata_ready;

endmodule

// File: tb/tb_native_bus_arbiter.sv
// Directed bench for native_bus_arbiter: a round-robin instance and a
// data-priority instance share the same stimulus.
module tb_native_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ir_raddr_valid, ir_rdata_ready, dr_raddr_valid, dr_rdata_ready;
  logic [31:0] ir_raddr, dr_raddr;
  logic        dw_waddr_valid, dw_wdata_valid;
  logic [31:0] dw_waddr, dw_wdata;
  logic        m_raddr_ready, m_rdata_valid, m_waddr_ready, m_wdata_ready;
  logic [31:0] m_rdata;

  logic        ir_raddr_ready, ir_rdata_valid, dr_raddr_ready, dr_rdata_valid;
  logic [31:0] ir_rdata, dr_rdata;
  logic        dw_waddr_ready, dw_wdata_ready;
  logic        m_raddr_valid, m_rdata_ready, m_waddr_valid, m_wdata_valid;
  logic [31:0] m_raddr, m_waddr, m_wdata;
  logic        err_rdata;

  logic        p_ir_raddr_ready, p_ir_rdata_valid, p_dr_raddr_ready, p_dr_rdata_valid;
  logic [31:0] p_ir_rdata, p_dr_rdata;
  logic        p_dw_waddr_ready, p_dw_wdata_ready;
  logic        p_m_raddr_valid, p_m_rdata_ready, p_m_waddr_valid, p_m_wdata_valid;
  logic [31:0] p_m_raddr, p_m_waddr, p_m_wdata;
  logic        p_err_rdata;

  int checks = 0;
  int errors = 0;

  native_bus_arbiter #(.bus_width(32), .max_outstanding(2), .data_priority(0)) dut (
    .clk(clk), .rst(rst),
    .ir_raddr_valid(ir_raddr_valid), .ir_raddr_ready(ir_raddr_ready), .ir_raddr(ir_raddr),
    .ir_rdata_valid(ir_rdata_valid), .ir_rdata_ready(ir_rdata_ready), .ir_rdata(ir_rdata),
    .dr_raddr_valid(dr_raddr_valid), .dr_raddr_ready(dr_raddr_ready), .dr_raddr(dr_raddr),
    .dr_rdata_valid(dr_rdata_valid), .dr_rdata_ready(dr_rdata_ready), .dr_rdata(dr_rdata),
    .dw_waddr_valid(dw_waddr_valid), .dw_waddr_ready(dw_waddr_ready), .dw_waddr(dw_waddr),
    .dw_wdata_valid(dw_wdata_valid), .dw_wdata_ready(dw_wdata_ready), .dw_wdata(dw_wdata),
    .m_raddr_valid(m_raddr_valid), .m_raddr_ready(m_raddr_ready), .m_raddr(m_raddr),
    .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready), .m_rdata(m_rdata),
    .m_waddr_valid(m_waddr_valid), .m_waddr_ready(m_waddr_ready), .m_waddr(m_waddr),
    .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready), .m_wdata(m_wdata),
    .err_rdata(err_rdata)
  );

  native_bus_arbiter #(.bus_width(32), .max_outstanding(2), .data_priority(1)) dut_prio (
    .clk(clk), .rst(rst),
    .ir_raddr_valid(ir_raddr_valid), .ir_raddr_ready(p_ir_raddr_ready), .ir_raddr(ir_raddr),
    .ir_rdata_valid(p_ir_rdata_valid), .ir_rdata_ready(ir_rdata_ready), .ir_rdata(p_ir_rdata),
    .dr_raddr_valid(dr_raddr_valid), .dr_raddr_ready(p_dr_raddr_ready), .dr_raddr(dr_raddr),
    .dr_rdata_valid(p_dr_rdata_valid), .dr_rdata_ready(dr_rdata_ready), .dr_rdata(p_dr_rdata),
    .dw_waddr_valid(dw_waddr_valid), .dw_waddr_ready(p_dw_waddr_ready), .dw_waddr(dw_waddr),
    .dw_wdata_valid(dw_wdata_valid), .dw_wdata_ready(p_dw_wdata_ready), .dw_wdata(dw_wdata),
    .m_raddr_valid(p_m_raddr_valid), .m_raddr_ready(m_raddr_ready), .m_raddr(p_m_raddr),
    .m_rdata_valid(m_rdata_valid), .m_rdata_ready(p_m_rdata_ready), .m_rdata(m_rdata),
    .m_waddr_valid(p_m_waddr_valid), .m_waddr_ready(m_waddr_ready), .m_waddr(p_m_waddr),
    .m_wdata_valid(p_m_wdata_valid), .m_wdata_ready(m_wdata_ready), .m_wdata(p_m_wdata),
    .err_rdata(p_err_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da);
    ir_raddr_valid = iv;
    ir_raddr       = ia;
    dr_raddr_valid = dv;
    dr_raddr       = da;
  endtask

  task automatic respond(input logic v, input logic [31:0] d);
    m_rdata_valid = v;
    m_rdata       = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    respond(1'b0, 32'h0);
    ir_rdata_ready = 1'b0;
    dr_rdata_ready = 1'b0;
    m_raddr_ready  = 1'b0;
    dw_waddr_valid = 1'b0;
    dw_waddr       = 32'h0;
    dw_wdata_valid = 1'b0;
    dw_wdata       = 32'h0;
    m_waddr_ready  = 1'b0;
    m_wdata_ready  = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    checkOutput("reset_m_raddr_valid", {31'b0, m_raddr_valid}, 32'h0);
    checkOutput("reset_m_raddr", m_raddr, 32'h0);
    checkOutput("reset_err", {31'b0, err_rdata}, 32'h0);
    checkOutput("reset_ir_ready", {31'b0, ir_raddr_ready}, 32'h0);
    checkOutput("reset_dr_ready", {31'b0, dr_raddr_ready}, 32'h0);
    checkOutput("reset_rdata_valids", {30'b0, ir_rdata_valid, dr_rdata_valid}, 32'h0);
    tick();
    rst = 1'b1;

    $display("[TB] round-robin and data-priority with both masters requesting");
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200);
    m_raddr_ready  = 1'b1;
    ir_rdata_ready = 1'b1;
    dr_rdata_ready = 1'b1;
    #1;
    checkOutput("rr0_ir_ready", {31'b0, ir_raddr_ready}, 32'h1);
    checkOutput("rr0_dr_ready", {31'b0, dr_raddr_ready}, 32'h0);
    checkOutput("prio0_ir_ready", {31'b0, p_ir_raddr_ready}, 32'h0);
    checkOutput("prio0_dr_ready", {31'b0, p_dr_raddr_ready}, 32'h1);
    tick();
    checkOutput("rr1_m_raddr_valid", {31'b0, m_raddr_valid}, 32'h1);
    checkOutput("rr1_m_raddr", m_raddr, 32'h100);
    checkOutput("rr1_ready_in_issue", {30'b0, ir_raddr_ready, dr_raddr_ready}, 32'h0);
    checkOutput("prio1_m_raddr", p_m_raddr, 32'h200);
    tick();
    respond(1'b1, 32'hA1);
    #1;
    checkOutput("rr2_dr_ready", {31'b0, dr_raddr_ready}, 32'h1);
    checkOutput("rr2_ir_ready", {31'b0, ir_raddr_ready}, 32'h0);
    checkOutput("rr2_ir_rdata_valid", {31'b0, ir_rdata_valid}, 32'h1);
    checkOutput("rr2_ir_rdata", ir_rdata, 32'hA1);
    checkOutput("rr2_dr_rdata_valid", {31'b0, dr_rdata_valid}, 32'h0);
    checkOutput("prio2_ir_ready", {31'b0, p_ir_raddr_ready}, 32'h0);
    checkOutput("prio2_dr_rdata_valid", {31'b0, p_dr_rdata_valid}, 32'h1);
    tick();
    respond(1'b0, 32'h0);
    #1;
    checkOutput("rr3_m_raddr", m_raddr, 32'h200);
    checkOutput("prio3_m_raddr", p_m_raddr, 32'h200);
    tick();
    respond(1'b1, 32'hB2);
    #1;
    checkOutput("rr4_ir_ready", {31'b0, ir_raddr_ready}, 32'h1);
    checkOutput("rr4_dr_rdata_valid", {31'b0, dr_rdata_valid}, 32'h1);
    checkOutput("rr4_dr_rdata", dr_rdata, 32'hB2);
    checkOutput("rr4_ir_rdata_valid", {31'b0, ir_rdata_valid}, 32'h0);
    checkOutput("prio4_ir_ready", {31'b0, p_ir_raddr_ready}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    respond(1'b0, 32'h0);
    #1;
    checkOutput("rr5_m_raddr", m_raddr, 32'h100);
    tick();
    respond(1'b1, 32'hC3);
    #1;
    checkOutput("rr6_ir_rdata_valid", {31'b0, ir_rdata_valid}, 32'h1);
    checkOutput("rr6_ir_rdata", ir_rdata, 32'hC3);
    checkOutput("prio6_dr_rdata_valid", {31'b0, p_dr_rdata_valid}, 32'h1);
    tick();
    respond(1'b0, 32'h0);

    $display("[TB] single instruction read");
    pulseReset();
    tick();
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0);
    m_raddr_ready = 1'b0;
    #1;
    checkOutput("single_ir_ready", {31'b0, ir_raddr_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    m_raddr_ready = 1'b1;
    #1;
    checkOutput("single_m_raddr_valid", {31'b0, m_raddr_valid}, 32'h1);
    checkOutput("single_m_raddr", m_raddr, 32'h10);
    tick();
    m_raddr_ready = 1'b0;
    #1;
    checkOutput("single_back_idle", {31'b0, m_raddr_valid}, 32'h0);
    tick();
    respond(1'b1, 32'hDEADBEEF);
    #1;
    checkOutput("single_ir_rdata_valid", {31'b0, ir_rdata_valid}, 32'h1);
    checkOutput("single_ir_rdata", ir_rdata, 32'hDEADBEEF);
    checkOutput("single_dr_rdata_valid", {31'b0, dr_rdata_valid}, 32'h0);
    checkOutput("single_m_rdata_ready", {31'b0, m_rdata_ready}, 32'h1);
    tick();
    respond(1'b0, 32'h0);
    #1;
    checkOutput("single_popped", {31'b0, ir_rdata_valid}, 32'h0);

    $display("[TB] owner FIFO full, backpressure and unexpected response");
    m_raddr_ready = 1'b1;
    tick();
    applyStimulus(1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    checkOutput("full0_ir_ready", {31'b0, ir_raddr_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h400);
    #1;
    checkOutput("full1_m_raddr", m_raddr, 32'h300);
    tick();
    checkOutput("full2_dr_ready", {31'b0, dr_raddr_ready}, 32'h1);
    tick();
    applyStimulus(1'b1, 32'h308, 1'b0, 32'h0);
    #1;
    checkOutput("full3_m_raddr", m_raddr, 32'h400);
    tick();
    checkOutput("full4_no_grant", {31'b0, ir_raddr_ready}, 32'h0);
    tick();
    respond(1'b1, 32'h11);
    #1;
    checkOutput("full5_ir_rdata_valid", {31'b0, ir_rdata_valid}, 32'h1);
    checkOutput("full5_no_grant_on_pop", {31'b0, ir_raddr_ready}, 32'h0);
    tick();
    respond(1'b0, 32'h0);
    #1;
    checkOutput("full6_ir_ready", {31'b0, ir_raddr_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    respond(1'b1, 32'h22);
    dr_rdata_ready = 1'b0;
    #1;
    checkOutput("full7_m_raddr", m_raddr, 32'h308);
    checkOutput("bp_dr_rdata_valid", {31'b0, dr_rdata_valid}, 32'h1);
    checkOutput("bp_m_rdata_ready", {31'b0, m_rdata_ready}, 32'h0);
    checkOutput("bp_ir_rdata_valid", {31'b0, ir_rdata_valid}, 32'h0);
    tick();
    checkOutput("bp_not_popped", {31'b0, dr_rdata_valid}, 32'h1);
    dr_rdata_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'b0, m_rdata_ready}, 32'h1);
    checkOutput("bp_dr_rdata", dr_rdata, 32'h22);
    tick();
    respond(1'b1, 32'h33);
    #1;
    checkOutput("tail_ir_rdata_valid", {31'b0, ir_rdata_valid}, 32'h1);
    checkOutput("tail_ir_rdata", ir_rdata, 32'h33);
    checkOutput("tail_dr_rdata_valid", {31'b0, dr_rdata_valid}, 32'h0);
    tick();
    checkOutput("unexp_m_rdata_ready", {31'b0, m_rdata_ready}, 32'h0);
    checkOutput("unexp_valids", {30'b0, ir_rdata_valid, dr_rdata_valid}, 32'h0);
    checkOutput("unexp_err_not_yet", {31'b0, err_rdata}, 32'h0);
    tick();
    respond(1'b0, 32'h0);
    #1;
    checkOutput("unexp_err_set", {31'b0, err_rdata}, 32'h1);
    tick();
    checkOutput("unexp_err_sticky", {31'b0, err_rdata}, 32'h1);

    $display("[TB] write passthrough");
    dw_waddr_valid = 1'b1;
    dw_waddr       = 32'h40;
    dw_wdata_valid = 1'b1;
    dw_wdata       = 32'h55;
    m_waddr_ready  = 1'b1;
    m_wdata_ready  = 1'b0;
    #1;
    checkOutput("wr_m_waddr", m_waddr, 32'h40);
    checkOutput("wr_m_wdata", m_wdata, 32'h55);
    checkOutput("wr_valids", {30'b0, m_waddr_valid, m_wdata_valid}, 32'h3);
    checkOutput("wr_readies", {30'b0, dw_waddr_ready, dw_wdata_ready}, 32'h2);

    $display("[TB] reset during issue");
    m_raddr_ready = 1'b0;
    tick();
    applyStimulus(1'b1, 32'h500, 1'b0, 32'h0);
    #1;
    checkOutput("rst_issue_ir_ready", {31'b0, ir_raddr_ready}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checkOutput("rst_issue_valid", {31'b0, m_raddr_valid}, 32'h1);
    checkOutput("rst_issue_addr", m_raddr, 32'h500);
    rst = 1'b0;
    #1;
    checkOutput("rst_async_valid", {31'b0, m_raddr_valid}, 32'h0);
    checkOutput("rst_async_addr", m_raddr, 32'h0);
    checkOutput("rst_async_err", {31'b0, err_rdata}, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
